// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions.
// Purpose : opcode encodings, the canonical NOP word and the queue entry
//           record used by the fetch stage, the fetch queue and decode.
// Ports   : none (package).
package fetch_queue_pkg;

    // Major opcodes (instr[6:0]) recognised by fetch and decode.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0 -- presented to decode whenever no entry is valid.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One queued fetch result.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        halt;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue between the fetch and decode stages.
// Purpose : small FIFO decoupling fetch from decode. Supports flush on
//           redirect, back-pressure on full, and a sticky halt once decode
//           consumes an entry flagged as an illegal opcode.
// Ports   : clk, rst (async, active-low)
//           push_valid/push_pc/push_instr/push_halt : entry from fetch
//           flush      : redirect, discards every queued entry
//           pop_ready  : decode accepts the head entry
//           IF_stall   : queue full, fetch holds its PC
//           out_valid/out_pc/out_instr/out_halt : head entry for decode
//           count      : number of valid entries
//           halted     : a halt entry has been consumed
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [31:0]                push_pc,
    input  logic [31:0]                push_instr,
    input  logic                       push_halt,
    input  logic                       flush,
    input  logic                       pop_ready,
    output logic                       IF_stall,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic                       out_halt,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fq_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    fq_entry_t          head;
    fq_entry_t          new_entry;
    logic               full;
    logic               push_fire;
    logic               pop_fire;

    // Full/empty come only from count; the pointers wrap naturally because
    // DEPTH is a power of two.
    assign full      = (count == CNT_W'(DEPTH));
    assign head      = mem[rd_ptr];
    assign new_entry = '{pc: push_pc, instr: push_instr, halt: push_halt};

    // A push while full is refused even if a pop frees a slot this cycle,
    // so IF_stall alone tells fetch whether its word was taken.
    assign push_fire = push_valid && !full && !flush && !halted;
    assign pop_fire  = out_valid && pop_ready && !flush;

    // Storage is not reset; count and the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointer, occupancy and halt bookkeeping. Flush beats push and pop
    // but leaves halted alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (head.halt) begin
                    halted <= 1'b1;
                end
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation: NOP with zero PC whenever nothing may be decoded.
    always_comb begin
        IF_stall  = full;
        out_valid = (count != '0) && !halted;
        out_pc    = 32'h0;
        out_instr = NOP_INSTR;
        out_halt  = 1'b0;
        if (out_valid) begin
            out_pc    = head.pc;
            out_instr = head.instr;
            out_halt  = head.halt;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue.
// Purpose : directed scenarios (fill, streaming, flush, halt, wrap, reset)
//           followed by randomized traffic. A queue-based reference model
//           predicts accepted pushes; expected head entries go into a
//           scoreboard that a free-running monitor compares and retires.
// Ports   : none (top-level bench).
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        halt;
    } model_entry_t;

    logic                       clk;
    logic                       rst;
    logic                       push_valid;
    logic [31:0]                push_pc;
    logic [31:0]                push_instr;
    logic                       push_halt;
    logic                       flush;
    logic                       pop_ready;
    logic                       IF_stall;
    logic                       out_valid;
    logic [31:0]                out_pc;
    logic [31:0]                out_instr;
    logic                       out_halt;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       halted;

    model_entry_t ref_q [$];
    model_entry_t exp_q [$];
    logic         model_halted;
    int           check_count;
    int           pass_count;
    logic [31:0]  next_pc;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .push_halt  (push_halt),
        .flush      (flush),
        .pop_ready  (pop_ready),
        .IF_stall   (IF_stall),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_halt   (out_halt),
        .count      (count),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs from a falling edge, lets the model decide
    // what the queue must do with them, and applies that at the rising edge.
    task automatic apply_stimulus(input logic pv, input logic [31:0] pc,
                                  input logic [31:0] instr, input logic ph,
                                  input logic fl, input logic pr);
        model_entry_t e;
        bit           do_push;
        bit           do_pop;
        push_valid = pv;
        push_pc    = pc;
        push_instr = instr;
        push_halt  = ph;
        flush      = fl;
        pop_ready  = pr;
        do_push = pv && (ref_q.size() < DEPTH) && !fl && !model_halted;
        do_pop  = (ref_q.size() != 0) && !model_halted && pr && !fl;
        @(posedge clk);
        if (fl) begin
            ref_q.delete();
            exp_q.delete();
        end else begin
            if (do_pop) begin
                e = ref_q.pop_front();
                if (e.halt) model_halted = 1'b1;
            end
            if (do_push) begin
                e.pc    = pc;
                e.instr = instr;
                e.halt  = ph;
                ref_q.push_back(e);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    // Pulls reset low between edges and checks the outputs respond at once.
    task automatic apply_reset();
        push_valid = 1'b0;
        flush      = 1'b0;
        pop_ready  = 1'b0;
        push_halt  = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        ref_q.delete();
        exp_q.delete();
        model_halted = 1'b0;
        check_output("rst_out_valid", 32'(out_valid), 32'h0);
        check_output("rst_IF_stall",  32'(IF_stall),  32'h0);
        check_output("rst_out_instr", out_instr,      NOP_INSTR);
        check_output("rst_out_pc",    out_pc,         32'h0);
        check_output("rst_out_halt",  32'(out_halt),  32'h0);
        check_output("rst_count",     32'(count),     32'h0);
        check_output("rst_halted",    32'(halted),    32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compares status every cycle, checks the head against the
    // scoreboard whenever the queue presents it, and retires it on a pop.
    initial begin
        model_entry_t exp_e;
        forever begin
            @(negedge clk);
            #2;
            check_output("out_valid", 32'(out_valid),
                         32'((ref_q.size() != 0) && !model_halted));
            check_output("count",     32'(count), 32'(ref_q.size()));
            check_output("IF_stall",  32'(IF_stall), 32'(ref_q.size() == DEPTH));
            check_output("halted",    32'(halted), 32'(model_halted));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("head_present", 32'h1, 32'h0);
                end else begin
                    exp_e = exp_q[0];
                    check_output("out_pc",    out_pc,         exp_e.pc);
                    check_output("out_instr", out_instr,      exp_e.instr);
                    check_output("out_halt",  32'(out_halt),  32'(exp_e.halt));
                    if (pop_ready && !flush) void'(exp_q.pop_front());
                end
            end else begin
                check_output("idle_instr", out_instr,     NOP_INSTR);
                check_output("idle_pc",    out_pc,        32'h0);
                check_output("idle_halt",  32'(out_halt), 32'h0);
            end
        end
    end

    initial begin
        check_count  = 0;
        pass_count   = 0;
        model_halted = 1'b0;
        next_pc      = 32'h1000;
        rst          = 1'b1;
        push_valid   = 1'b0;
        push_pc      = 32'h0;
        push_instr   = 32'h0;
        push_halt    = 1'b0;
        flush        = 1'b0;
        pop_ready    = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Fill to full with decode stalled; the fifth word is refused.
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        check_output("fill_stall", 32'(IF_stall), 32'h1);
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Streaming: push and pop every cycle from empty.
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b1, 32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Flush with a concurrent push and pop.
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 32'h200 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h20C, 32'hC000_0003, 1'b0, 1'b1, 1'b1);
        check_output("flush_count", 32'(count), 32'h0);
        check_output("flush_instr", out_instr, NOP_INSTR);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Halt: 0x24 is flagged, 0x28 must never reach decode.
        apply_stimulus(1'b1, 32'h20, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h24, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h28, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 32'h2C + 32'(i * 4), 32'h0000_0013, 1'b0, 1'b0, 1'b1);
        check_output("halt_sticky", 32'(halted), 32'h1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_output("halt_after_flush", 32'(halted), 32'h1);
        apply_reset();

        // Wrap: hold two entries and stream across the pointer wrap.
        for (int i = 0; i < 2; i++)
            apply_stimulus(1'b1, 32'h300 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < 12; i++)
            apply_stimulus(1'b1, 32'h300 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset mid-operation with three entries queued.
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 32'h400 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        apply_reset();

        // Randomized traffic with occasional flush, halt and reset.
        for (int i = 0; i < 2000; i++) begin
            if (model_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 399) == 0)) begin
                apply_reset();
            end else begin
                logic pv;
                pv = ($urandom_range(0, 3) != 0);
                apply_stimulus(pv, next_pc, $urandom, ($urandom_range(0, 79) == 0),
                               ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0));
                next_pc = next_pc + 32'h4;
            end
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 push_valid  input  1  fetch stage presents a fetched instruction this cycle.
REQ-005 push_pc  input  32  PC of the pushed instruction.
REQ-006 push_instr  input  32  fetched instruction word.
REQ-007 push_halt  input  1  fetch stage flagged an illegal opcode (halt) for this word.
REQ-008 flush  input  1  redirect from execute (npc_control); discards all queued entries.
REQ-009 pop_ready  input  1  decode stage accepts the head entry this cycle.
REQ-010 IF_stall  output  1  queue full; fetch holds its PC.
REQ-011 out_valid  output  1  head entry valid for decode.
REQ-012 out_pc  output  32  PC of the head entry.
REQ-013 out_instr  output  32  instruction of the head entry.
REQ-014 out_halt  output  1  halt flag of the head entry.
REQ-015 count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-016 halted  output  1  sticky: a halt entry has been consumed by decode.

Function
REQ-017 Push fires when push_valid=1, IF_stall=0, flush=0 and halted=0; the entry is written at the tail.
REQ-018 Pop fires when out_valid=1, pop_ready=1 and flush=0; the head advances one entry.
REQ-019 Simultaneous push and pop: both take effect; count unchanged.
REQ-020 IF_stall = (count==DEPTH), combinational from registered count; a push while full is not accepted, even if a pop fires in the same cycle.
REQ-021 out_valid = (count!=0) and halted=0; out_* driven combinationally from the head entry, zero latency from registered state.
REQ-022 When out_valid=0: out_instr SHALL be 32'h00000013 (NOP), out_pc 0, out_halt 0.
REQ-023 First-in-first-out order; an entry pushed into an empty queue appears on out_* in the following cycle (one-cycle latency).
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full/empty derive from count only.
REQ-025 flush=1: on the next edge count=0 and both pointers=0; same-cycle push and pop are ignored; flush takes priority over all other events.
REQ-026 When a pop fires with out_halt=1, halted SHALL set on that edge and remain set until reset; no further pushes or pops occur and out_valid stays 0.
REQ-027 flush does not clear halted.
REQ-028 Stored entries not yet popped SHALL retain their data across stall cycles without change.

Reset
REQ-029 rst=0 asynchronously clears count, pointers and halted; outputs become out_valid=0, IF_stall=0, out_instr=32'h00000013, out_pc=0, out_halt=0, count=0, halted=0.
REQ-030 Reset mid-operation discards all entries; storage array contents need not be cleared.
REQ-031 After rst deasserts, the first push is accepted at the first rising edge with rst=1.

Structure
REQ-032 The NOP encoding constant and opcode definitions SHALL reside in the shared defines file used by the fetch and decode stages.
REQ-033 Storage, pointers and count in a single module; no sub-module required.

Verification
REQ-034 Fill: push PCs 0x00,0x04,0x08,0x0C with pop_ready=0 -> count=4, IF_stall=1; fifth push (0x10) rejected; pops return 0x00..0x0C in order.
REQ-035 Streaming: continuous push and pop_ready=1 from empty -> out_pc lags push_pc by one cycle, count stays 1, IF_stall never asserts.
REQ-036 Flush: 3 entries queued, flush=1 with push_valid=1 and pop_ready=1 -> next cycle count=0, out_valid=0, out_instr=0x00000013.
REQ-037 Halt: push 0x20 (push_halt=0), then 0x24 (push_halt=1), then 0x28; pop all -> 0x20 and 0x24 delivered, halted=1 after 0x24 pop, 0x28 never presented.
REQ-038 Wrap: 10 push/pop cycles with DEPTH=4 at count 2-3 -> order preserved across pointer wrap, no lost or duplicated PC.
REQ-039 Reset mid-operation: count=3, rst pulsed low between clock edges -> outputs take reset values immediately, not at the next edge.
